// File: rtl/wish_unpack.sv
// Wishbone-style width down-converter: one NUM_PACK*DATA_WIDTH word in, NUM_PACK beats out.
// Optional macro WISH_UNPACK_STALL_EN drives s_stall_o for pipelined Wishbone sources.
module wish_unpack #(
   parameter int DATA_WIDTH    = 8,
   parameter int NUM_PACK      = 4,
   parameter int LITTLE_ENDIAN = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           s_stb_i,
   input  logic                           s_cyc_i,
   output logic                           s_ack_o,
   output logic                           s_stall_o,
   input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
   input  logic [1:0]                     s_tgc_i,
   output logic                           d_stb_o,
   output logic                           d_cyc_o,
   input  logic                           d_ack_i,
   output logic [DATA_WIDTH-1:0]          d_dat_o,
   output logic [1:0]                     d_tgc_o
);
   localparam int WORD_W = DATA_WIDTH * NUM_PACK;
   localparam int IDX_W  = $clog2(NUM_PACK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

   logic [WORD_W-1:0]     dat_q;
   logic [1:0]            tgc_q;
   logic                  full_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  beat_go;
   logic                  last_go;
   logic                  at_last;
   logic [DATA_WIDTH-1:0] beats [NUM_PACK];

   // Beat k in output order; endianness only changes which slice feeds it.
   for (genvar k = 0; k < NUM_PACK; k++) begin : g_beat
      if (LITTLE_ENDIAN != 0) begin : g_le
         assign beats[k] = dat_q[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_be
         assign beats[k] = dat_q[(NUM_PACK-1-k)*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign at_last = (idx_q == LAST_IDX);
   assign beat_go = full_q && d_ack_i;
   assign last_go = beat_go && at_last;

   // Accepting while the final beat drains keeps back-to-back words bubble-free.
   assign s_ack_o = s_stb_i && s_cyc_i && !rst_i && (!full_q || last_go);

`ifdef WISH_UNPACK_STALL_EN
   assign s_stall_o = full_q && !last_go;
`else
   assign s_stall_o = 1'b0;
`endif

   assign d_stb_o = full_q;
   assign d_cyc_o = full_q;
   assign d_dat_o = beats[idx_q];
   assign d_tgc_o = {at_last & tgc_q[1], (idx_q == '0) & tgc_q[0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dat_q  <= '0;
         tgc_q  <= '0;
         full_q <= 1'b0;
         idx_q  <= '0;
      end else if (s_ack_o) begin
         dat_q  <= s_dat_i;
         tgc_q  <= s_tgc_i;
         full_q <= 1'b1;
         idx_q  <= '0;
      end else if (beat_go) begin
         if (at_last) begin
            idx_q  <= '0;
            full_q <= 1'b0;
         end else begin
            idx_q  <= idx_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wish_unpack.sv
// Scoreboard bench for wish_unpack: one LSB-first and one MSB-first instance share stimulus.
module tb_wish_unpack;
   logic        clk = 1'b0;
   logic        rst;
   logic        s_stb, s_cyc, d_ack;
   logic [31:0] s_dat;
   logic [1:0]  s_tgc;
   logic        le_ack, le_stall, le_stb, le_cyc;
   logic        be_ack, be_stall, be_stb, be_cyc;
   logic [7:0]  le_dat, be_dat;
   logic [1:0]  le_tgc, be_tgc;
   logic [9:0]  q_le[$];
   logic [9:0]  q_be[$];
   int          checks = 0;
   int          errs = 0;
`ifdef WISH_UNPACK_STALL_EN
   localparam logic STALL_EXP = 1'b1;
`else
   localparam logic STALL_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(1)) u_le (
      .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(le_ack),
      .s_stall_o(le_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(le_stb),
      .d_cyc_o(le_cyc), .d_ack_i(d_ack), .d_dat_o(le_dat), .d_tgc_o(le_tgc));

   wish_unpack #(.DATA_WIDTH(8), .NUM_PACK(4), .LITTLE_ENDIAN(0)) u_be (
      .clk_i(clk), .rst_i(rst), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_ack_o(be_ack),
      .s_stall_o(be_stall), .s_dat_i(s_dat), .s_tgc_i(s_tgc), .d_stb_o(be_stb),
      .d_cyc_o(be_cyc), .d_ack_i(d_ack), .d_dat_o(be_dat), .d_tgc_o(be_tgc));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] beat_tag(input int k, input logic [1:0] t);
      return {(k == 3) ? t[1] : 1'b0, (k == 0) ? t[0] : 1'b0};
   endfunction

   // Monitor: the head of each queue must be on the bus whenever strobe is up.
   always @(negedge clk) begin
      if (!rst) begin
         if (le_stb) begin
            chk("le_cyc", le_cyc, 1);
            if (q_le.size() == 0) chk("le_extra_beat", 1, 0);
            else begin
               chk("le_dat", le_dat, q_le[0][7:0]);
               chk("le_tgc", le_tgc, q_le[0][9:8]);
               if (d_ack) void'(q_le.pop_front());
            end
         end
         if (be_stb) begin
            chk("be_cyc", be_cyc, 1);
            if (q_be.size() == 0) chk("be_extra_beat", 1, 0);
            else begin
               chk("be_dat", be_dat, q_be[0][7:0]);
               chk("be_tgc", be_tgc, q_be[0][9:8]);
               if (d_ack) void'(q_be.pop_front());
            end
         end
         if (le_ack) begin
            for (int k = 0; k < 4; k++) begin
               q_le.push_back({beat_tag(k, s_tgc), s_dat[k*8 +: 8]});
               q_be.push_back({beat_tag(k, s_tgc), s_dat[(3-k)*8 +: 8]});
            end
         end
      end
   end

   // Offer a word until acked; every refused cycle must show the stall level.
   task automatic send(input logic [31:0] d, input logic [1:0] t);
      s_stb = 1'b1; s_cyc = 1'b1; s_dat = d; s_tgc = t;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (le_ack) break;
         chk("stall_while_full", le_stall, STALL_EXP);
         chk("be_ack_held", be_ack, 0);
         if (n > 50) begin chk("send_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      s_stb = 1'b0; s_cyc = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; ; n++) begin
         @(negedge clk);
         if (!le_stb && !be_stb) break;
         if (n > 50) begin chk("drain_timeout", 1, 0); break; end
      end
      chk("le_q_empty", q_le.size(), 0);
      chk("be_q_empty", q_be.size(), 0);
   endtask

   initial begin
      rst = 1'b1; s_stb = 1'b1; s_cyc = 1'b1; d_ack = 1'b1;
      s_dat = 32'hDEADBEEF; s_tgc = 2'b11;
      repeat (2) @(negedge clk);
      chk("rst_ack", le_ack, 0);
      chk("rst_stall", le_stall, 0);
      chk("rst_stb", le_stb, 0);
      chk("rst_cyc", le_cyc, 0);
      chk("rst_dat", le_dat, 0);
      chk("rst_tgc", le_tgc, 0);
      chk("rst_be_stb", be_stb, 0);
      chk("rst_be_dat", be_dat, 0);
      s_stb = 1'b0; s_cyc = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // single word, tags 11
      send(32'hDDCCBBAA, 2'b11);
      drain();
      chk("idle_stb", le_stb, 0);

      // back-to-back: second word accepted on the first word's last beat
      send(32'hDDCCBBAA, 2'b11);
      fork
         send(32'h44332211, 2'b11);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("b2b_no_gap", le_stb, 1);
            end
         end
      join
      drain();

      // destination backpressure with a source pushing against a full buffer
      d_ack = 1'b0;
      fork
         begin
            send(32'h87654321, 2'b11);
            send(32'h0FEDCBA9, 2'b10);
         end
         begin
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1 d_ack = ~d_ack;
            end
            d_ack = 1'b1;
         end
      join
      drain();

      // tag masking
      send(32'h13579BDF, 2'b00);
      send(32'h2468ACE0, 2'b01);
      drain();

      // reset in the middle of a word
      send(32'hA5A55A5A, 2'b11);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_le_stb", le_stb, 0);
      chk("midrst_be_stb", be_stb, 0);
      q_le.delete();
      q_be.delete();
      @(posedge clk); #1 rst = 1'b0;
      send(32'hCAFEF00D, 2'b11);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
      $finish;
   end
endmodule
